apb_mem_slave: RTL
==================

# apb_mem_slave

Parametrised APB slave that fronts a word-organised register-file memory. It supports:
- configurable data/address width and depth,
- APB4 byte strobes,
- PSLVERR on out-of-range addresses,
- selectable wait-state insertion: none, fixed, or pseudo-random from an LFSR.

It is the next-generation memory slave behind the APB master. It replaces the fixed 8-bit/32-bit, random-wait-only slave. It adds an explicit transfer FSM with defined abort and error behaviour.

## Interface
- ADDR_W, 8, byte-address width of paddr_i.
- DATA_W, 32, data width; multiple of 8; STRB_W = DATA_W/8.
- DEPTH, 64, number of DATA_W words; word index = paddr_i[ADDR_W-1:$clog2(STRB_W)].
- WAIT_MODE, 0, wait-state source: 0 none, 1 fixed, 2 LFSR.
- FIXED_WAIT, 2, wait states per transfer when WAIT_MODE=1.
- LFSR_W, 3, LFSR width when WAIT_MODE=2; legal range 3..8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_W  byte address; low $clog2(STRB_W) bits ignored.
- pwdata_i  in  DATA_W  write data.
- pstrb_i  in  STRB_W  byte-lane write enables; ignored on reads.
- prdata_o  out  DATA_W  read data; nonzero only in read completion cycle.
- pready_o  out  1  transfer completes this cycle.
- pslverr_o  out  1  error response; valid only with pready_o.

## Operation
- FSM has two states: IDLE and ACCESS.
- IDLE → ACCESS when psel_i & ~penable_i (setup phase). On that edge:
  - load wait counter with N;
  - latch oor_q = (word index >= DEPTH);
  - latch rd_q = mem[index], or 0 if out of range.
- Any other input in IDLE (including penable_i without prior setup): stay IDLE, pready_o=0.
- ACCESS, cnt != 0: decrement cnt; pready_o=0.
- ACCESS, cnt == 0, psel_i=1: completion cycle.
  - pready_o=1 and pslverr_o=oor_q.
  - prdata_o = rd_q if ~pwrite_i, else 0.
  - On write with ~oor_q: on this edge, write each byte lane i where pstrb_i[i]=1.
  - Next state IDLE.
- ACCESS with psel_i=0 is an abort: next state IDLE, no write, no pready_o.
- N source:
  - WAIT_MODE 0: N=0.
  - WAIT_MODE 1: N=FIXED_WAIT.
  - WAIT_MODE 2: N = LFSR value in the setup cycle (range 1..2^LFSR_W-1).
- LFSR is Fibonacci, left-shift: next = {q[W-2:0], XOR of taps}.
  - Free-runs every cycle, including during reset release.
  - Seed 1<<(LFSR_W-1).
  - Taps for W=3: q[2]^q[0]; sequence 4,1,3,7,6,5,2,4…
- Counter width = $clog2(max(FIXED_WAIT, 2^LFSR_W-1)+1).
- Memory contents are not reset.
- Out-of-range write: completes with pslverr_o=1; memory unchanged.
- Out-of-range read: completes with pslverr_o=1, prdata_o=0.
- Write with pstrb_i=0: completes normally, no change.

## Timing
- Reset (rst=1 at an edge), effective the next cycle:
  - state=IDLE, cnt=0, oor_q=0, rd_q=0, LFSR=seed.
  - pready_o=0, pslverr_o=0, prdata_o=0.
- Outputs are combinational from state/cnt/registers and pwrite_i/psel_i; no combinational path from paddr_i or pwdata_i.
- Setup cycle T0, first access cycle T1: pready_o high in exactly cycle T1+N, for one cycle.
- Back-to-back: the cycle after completion may be the next setup. It is accepted because state is IDLE.
- Reset during ACCESS: transfer dropped, no write, pready_o low from next cycle.
- Read data reflects memory at T0. No other writer exists, so it equals memory at completion.

## Structure
- Package apb_mem_pkg holds:
  - state enum (IDLE, ACCESS);
  - WAIT_MODE encodings (WAIT_NONE=0, WAIT_FIXED=1, WAIT_LFSR=2);
  - LFSR tap masks for W=3..8;
  - helper function max_wait(mode, fixed, lfsr_w).
- Sub-module apb_lfsr (param LFSR_W; ports clk, rst, lfsr_o). Instantiated only when WAIT_MODE=2; otherwise tie N to 0/FIXED_WAIT.
- Memory is an array of DEPTH×DATA_W with per-byte write in always_ff.

## Test plan
- WAIT_MODE=0, write 0xDEADBEEF to paddr 0x10 with pstrb 0xF, then read 0x10:
  - pready_o in T1 both times;
  - read prdata_o=0xDEADBEEF, pslverr_o=0.
- Byte strobes: write 0x11223344 with pstrb 0x5 over 0xDEADBEEF at 0x10; read 0x10 → 0xDE22BE44.
- WAIT_MODE=1, FIXED_WAIT=3: pready_o low T1–T3, high in T4 only. Write lands only at the T4 edge (read back confirms).
- WAIT_MODE=2, LFSR_W=3, setup in first cycle after reset release:
  - LFSR=4 → pready_o at T5;
  - immediately following transfers use later LFSR samples; check against the sequence 4,1,3,7,6,5,2.
- DEPTH=32, write to paddr 0x80 (index 32):
  - pready_o=1, pslverr_o=1;
  - subsequent read of 0x80 → pslverr_o=1, prdata_o=0;
  - index 0 unaltered.
- Abort and reset, WAIT_MODE=1, FIXED_WAIT=2:
  - psel_i dropped in T1 → no write, no pready_o, next transfer completes normally;
  - rst asserted in T2 → no write, all outputs 0.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types, wait-mode encodings and LFSR taps
// for the APB memory slave and its wait-state generator.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WAIT_NONE  = 0;
  localparam int WAIT_FIXED = 1;
  localparam int WAIT_LFSR  = 2;

  // Feedback masks for a left-shifting Fibonacci LFSR, maximal length.
  localparam logic [7:0] TAPS_3 = 8'h05;
  localparam logic [7:0] TAPS_4 = 8'h0C;
  localparam logic [7:0] TAPS_5 = 8'h14;
  localparam logic [7:0] TAPS_6 = 8'h30;
  localparam logic [7:0] TAPS_7 = 8'h60;
  localparam logic [7:0] TAPS_8 = 8'hB8;

  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] t;
    case (w)
      4:       t = TAPS_4;
      5:       t = TAPS_5;
      6:       t = TAPS_6;
      7:       t = TAPS_7;
      8:       t = TAPS_8;
      default: t = TAPS_3;
    endcase
    return t;
  endfunction

  // Largest wait count the counter must hold; never below 1.
  function automatic int max_wait(
    input int mode,
    input int fixed,
    input int lfsr_w
  );
    int m;
    m = (1 << lfsr_w) - 1;
    if (fixed > m) m = fixed;
    if (mode == WAIT_NONE && m < 1) m = 1;
    return m;
  endfunction

endpackage

// File: rtl/apb_mem_slave_lfsr.sv
// apb_lfsr: free-running Fibonacci LFSR, reloads seed on reset.
// Ports: clk, rst (sync, active-high), lfsr_o (current value).
module apb_lfsr
  import apb_mem_pkg::*;
#(
  parameter int LFSR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr_o
);

  localparam logic [LFSR_W-1:0] TAPS =
    LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED =
    LFSR_W'(1) << (LFSR_W - 1);

  logic [LFSR_W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {q[LFSR_W-2:0], ^(q & TAPS)};
  end

  assign lfsr_o = q;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 slave over a byte-writable word memory with
// PSLVERR on out-of-range and none/fixed/LFSR wait-state insertion.
// Ports: clk, rst (sync, active-high), APB psel/penable/pwrite/
// paddr/pwdata/pstrb in; prdata/pready/pslverr out.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int WAIT_MODE  = 0,
  parameter int FIXED_WAIT = 2,
  parameter int LFSR_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  =
    $clog2(max_wait(WAIT_MODE, FIXED_WAIT, LFSR_W) + 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n, wait_n;
  logic                oor_q, oor_n;
  logic [DATA_W-1:0]   rd_q, rd_n;
  logic [MEM_AW-1:0]   widx_q, widx_n;
  logic [IDX_W-1:0]    idx;
  logic                in_range;
  logic                done;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Low byte-offset bits select nothing in a word-wide memory.
  logic unused_addr;
  assign unused_addr = ^paddr_i;

  assign idx      = paddr_i[ADDR_W-1:OFF_W];
  assign in_range = 32'(idx) < 32'(DEPTH);

  if (WAIT_MODE == WAIT_LFSR) begin : g_lfsr
    logic [LFSR_W-1:0] lfsr;
    apb_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_o (lfsr)
    );
    assign wait_n = CNT_W'(lfsr);
  end else if (WAIT_MODE == WAIT_FIXED) begin : g_fixed
    assign wait_n = CNT_W'(FIXED_WAIT);
  end else begin : g_none
    assign wait_n = '0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    oor_n   = oor_q;
    rd_n    = rd_q;
    widx_n  = widx_q;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_n = ACCESS;
          cnt_n   = wait_n;
          oor_n   = !in_range;
          widx_n  = MEM_AW'(idx);
          rd_n    = in_range ? mem[MEM_AW'(idx)] : '0;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pready_o  = done;
  assign pslverr_o = done & oor_q;
  assign prdata_o  = (done && !pwrite_i) ? rd_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      oor_q  <= 1'b0;
      rd_q   <= '0;
      widx_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      oor_q  <= oor_n;
      rd_q   <= rd_n;
      widx_q <= widx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && done && pwrite_i && !oor_q) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (pstrb_i[i])
          mem[widx_q][8*i +: 8] <= pwdata_i[8*i +: 8];
      end
    end
  end

endmodule
